// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU group.
// One trial subtraction per cycle, one quotient bit per cycle; divide-by-zero
// and signed overflow bypass the iteration and finish in a single cycle.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    count;
   logic             op_rem;
   logic             q_neg;
   logic             r_neg;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic             div_zero;
   logic             overflow;
   logic             special;
   logic [WIDTH-1:0] special_res;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   // Operand conditioning, special-case detection and the trial subtraction
   always_comb begin
      a_neg       = ~op[0] & dividend[WIDTH-1];
      b_neg       = ~op[0] & divisor[WIDTH-1];
      a_abs       = a_neg ? -dividend : dividend;
      b_abs       = b_neg ? -divisor : divisor;
      div_zero    = (divisor == '0);
      overflow    = ~op[0] & (dividend == MIN_NEG) & (divisor == '1);
      special     = div_zero | overflow;
      if (div_zero) begin
         special_res = op[1] ? dividend : '1;
      end else begin
         special_res = op[1] ? '0 : MIN_NEG;
      end
      rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvsr};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush always returns to IDLE and beats start
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE: if (start) state_next = special ? DONE : CALC;
            CALC: if (count == LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath, counter and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    <= '0;
         quo    <= '0;
         dvsr   <= '0;
         count  <= '0;
         op_rem <= 1'b0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
         busy   <= 1'b0;
         valid  <= 1'b0;
      end else begin
         busy  <= (state_next != IDLE);
         valid <= (state == DONE) && !flush;
         if (!flush) begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     rem    <= '0;
                     quo    <= a_abs;
                     dvsr   <= b_abs;
                     count  <= '0;
                     op_rem <= op[1];
                     q_neg  <= a_neg ^ b_neg;
                     r_neg  <= a_neg;
                     if (special) begin
                        result <= special_res;
                     end
                  end
               end
               CALC: begin
                  rem   <= trial[WIDTH] ? rem_sh : trial;
                  quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                  count <= count + CW'(1);
               end
               FIX: begin
                  if (op_rem) begin
                     result <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                  end else begin
                     result <= q_neg ? -quo : quo;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
